// File: rtl/perf_counter_pkg.sv
// Shared encodings for the performance-counter slave and its hardware master.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    OP_GO     = 2'd0,
    OP_STOP   = 2'd1,
    OP_GRESET = 2'd2,
    OP_READ   = 2'd3
  } op_e;

  localparam logic [1:0] OFF_TIME_LO = 2'd0;
  localparam logic [1:0] OFF_TIME_HI = 2'd1;
  localparam logic [1:0] OFF_EVENT   = 2'd2;
  localparam logic [1:0] OFF_STOP    = 2'd0;
  localparam logic [1:0] OFF_GO      = 2'd1;

  localparam int SECTION_STRIDE = 4;
  localparam int NUM_SECTIONS   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  // Word index inside the slave's register window.
  function automatic logic [3:0] word_index(input logic [1:0] section, input logic [1:0] off);
    return 4'(int'(section) * SECTION_STRIDE + int'(off));
  endfunction

endpackage

// File: rtl/perf_counter_master_if.sv
// Avalon-MM bus between the counter master and the counter control slave.
interface perf_counter_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/perf_counter_master.sv
// Hardware master turning GO/STOP/GLOBAL_RESET/READ commands into counter-slave bus cycles.
// Latency: writes 1 bus cycle, READ three non-pipelined reads then a one-cycle rsp_valid pulse.
// Backpressure: cmd_ready only in IDLE, waitrequest stalls in place; watchdog via PERF_COUNTER_MASTER_TIMEOUT_EN.
module perf_counter_master
  import perf_counter_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_section,
  output logic        rsp_valid,
  output logic [63:0] rsp_time,
  output logic [31:0] rsp_event,
  output logic        rsp_error,
  perf_counter_master_if.master avm
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [1:0]  sec_q;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] slot_q [3];
  logic [63:0] rsp_time_q;
  logic [31:0] rsp_event_q;
  logic [31:0] event_d;
  logic        cmd_acc;
  logic        capture;
  logic        load_rsp;
  logic        timeout;
  logic        wr_req;
  logic        rd_req;
  logic        busy;
  logic [3:0]  word;

  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign busy      = (state_q == ST_WR) || (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_time  = rsp_time_q;
  assign rsp_event = rsp_event_q;

`ifdef PERF_COUNTER_MASTER_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        rsp_error_q;

  assign timeout   = busy && (wd_q == 16'hFFFF);
  assign rsp_error = rsp_error_q;

  // Watchdog restarts on every state change so each bus phase gets a full window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q        <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (!busy || (state_d != state_q)) wd_q <= '0;
      else                               wd_q <= wd_q + 16'd1;
      if (cmd_acc)                             rsp_error_q <= 1'b0;
      else if (timeout && (op_q == OP_READ))   rsp_error_q <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    load_rsp = 1'b0;
    event_d  = avm.avm_readdata;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          state_d = (op_e'(cmd_op) == OP_READ) ? ST_RD_ISSUE : ST_WR;
          idx_d   = 2'd0;
        end
      end
      ST_WR: begin
        wr_req = 1'b1;
        if (!avm.avm_waitrequest) state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        rd_req = 1'b1;
        if (!avm.avm_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          capture = 1'b1;
          if (idx_q < 2'd2) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_RD_ISSUE;
          end else begin
            load_rsp = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A stuck slave abandons the transfer; a READ still reports what was captured.
    if (timeout) begin
      wr_req   = 1'b0;
      rd_req   = 1'b0;
      capture  = 1'b0;
      idx_d    = idx_q;
      load_rsp = 1'b0;
      if (op_q == OP_READ) begin
        state_d  = ST_RESP;
        load_rsp = 1'b1;
        event_d  = slot_q[2];
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    word = word_index(2'd0, OFF_STOP);
    case (op_q)
      OP_GO:   word = word_index(sec_q, OFF_GO);
      OP_READ: word = word_index(sec_q, idx_q);
      default: word = word_index(2'd0, OFF_STOP);
    endcase
  end

  assign avm.avm_write     = wr_req;
  assign avm.avm_read      = rd_req;
  assign avm.avm_address   = (wr_req || rd_req) ? (BASE_ADDR + ADDR_W'({word, 2'b00})) : '0;
  assign avm.avm_writedata = (wr_req && (op_q == OP_GRESET)) ? 32'd1 : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_GO;
      sec_q       <= 2'd0;
      idx_q       <= 2'd0;
      rsp_time_q  <= '0;
      rsp_event_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cmd_acc) begin
        op_q  <= op_e'(cmd_op);
        sec_q <= cmd_section;
      end
      if (load_rsp) begin
        rsp_time_q  <= {slot_q[1], slot_q[0]};
        rsp_event_q <= event_d;
      end
    end
  end

  // Slots are cleared per READ so a timed-out result never carries stale words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else if (cmd_acc && (op_e'(cmd_op) == OP_READ)) begin
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else if (capture) begin
      slot_q[idx_q] <= avm.avm_readdata;
    end
  end

endmodule

// File: tb/tb_perf_counter_master.sv
// Scoreboard bench: random commands against a memory-backed slave model with random stalls and latency.
module tb_perf_counter_master;
  import perf_counter_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_section = 2'd0;
  logic        rsp_valid;
  logic [63:0] rsp_time;
  logic [31:0] rsp_event;
  logic        rsp_error;

  always #5 clk = ~clk;

  perf_counter_master_if #(.ADDR_W(32)) avm ();

  perf_counter_master #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_section (cmd_section),
    .rsp_valid   (rsp_valid),
    .rsp_time    (rsp_time),
    .rsp_event   (rsp_event),
    .rsp_error   (rsp_error),
    .avm         (avm)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [63:0] t;
    logic [31:0] e;
    logic        err;
  } rsp_t;

  int   total = 0;
  int   bad = 0;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];

  logic [31:0] mem [16];
  int   wait_pct = 0;
  int   stall_left = 0;
  int   max_lat = 1;
  bit   mute = 1'b0;
  bit   pending = 1'b0;
  int   countdown = 0;
  int   pend_word = 0;
  int   wr_hi_cycles = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Reference model: what the counter slave must see for a command, and what READ returns.
  function automatic void model_cmd(input int op, input int sec);
    bus_t b;
    rsp_t r;
    b = '0;
    case (op)
      0: begin b.wr = 1'b1; b.addr = BASE + 32'((sec * 4 + 1) * 4); b.data = 32'd0; exp_bus.push_back(b); end
      1: begin b.wr = 1'b1; b.addr = BASE;                          b.data = 32'd0; exp_bus.push_back(b); end
      2: begin b.wr = 1'b1; b.addr = BASE;                          b.data = 32'd1; exp_bus.push_back(b); end
      default: begin
        for (int k = 0; k < 3; k++) begin
          b = '0;
          b.rd = 1'b1;
          b.addr = BASE + 32'((sec * 4 + k) * 4);
          exp_bus.push_back(b);
        end
        r.t = {mem[sec * 4 + 1], mem[sec * 4]};
        r.e = mem[sec * 4 + 2];
        r.err = 1'b0;
        exp_rsp.push_back(r);
      end
    endcase
  endfunction

  // Slave model: random stalls, 1..max_lat read latency, stray readdatavalid when no read is due.
  initial begin
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdata      = '0;
    avm.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = $urandom;
      if (!reset_n) begin
        pending = 1'b0;
        avm.avm_waitrequest = 1'b0;
      end else begin
        if (pending) begin
          if (!mute) begin
            if (countdown == 0) begin
              avm.avm_readdatavalid = 1'b1;
              avm.avm_readdata      = mem[pend_word];
              pending = 1'b0;
            end else begin
              countdown--;
            end
          end
        end else if ($urandom_range(0, 7) == 0) begin
          avm.avm_readdatavalid = 1'b1;
        end
        if (avm.avm_read || avm.avm_write) begin
          if (stall_left > 0) begin
            avm.avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm.avm_waitrequest = ($urandom_range(0, 99) < wait_pct);
          end
        end else begin
          avm.avm_waitrequest = 1'($urandom_range(0, 1));
        end
        if (avm.avm_read && !avm.avm_waitrequest) begin
          pending   = 1'b1;
          countdown = $urandom_range(0, max_lat - 1);
          pend_word = int'(4'((avm.avm_address - BASE) >> 2));
        end
      end
    end
  end

  // Monitor: bus transfers, stall stability, response pulse and hold.
  initial begin
    bus_t cur;
    bus_t prev;
    bus_t e;
    rsp_t act;
    rsp_t last_rsp;
    bit   prev_stall;
    bit   prev_rv;
    prev = '0;
    prev_stall = 1'b0;
    prev_rv = 1'b0;
    last_rsp = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_stall = 1'b0;
        prev_rv = 1'b0;
        last_rsp = '0;
      end else begin
        cur.rd   = avm.avm_read;
        cur.wr   = avm.avm_write;
        cur.addr = avm.avm_address;
        cur.data = avm.avm_write ? avm.avm_writedata : 32'd0;
        if (prev_stall) check("stall_hold", 128'(cur), 128'(prev));
        if (avm.avm_write) wr_hi_cycles++;
        if ((cur.rd || cur.wr) && !avm.avm_waitrequest) begin
          if (exp_bus.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bus_xfer: got %0h expected none", cur);
          end else begin
            e = exp_bus.pop_front();
            check("bus_xfer", 128'(cur), 128'(e));
          end
        end
        prev_stall = (cur.rd || cur.wr) && avm.avm_waitrequest;
        prev = cur;
        act.t = rsp_time;
        act.e = rsp_event;
        act.err = rsp_error;
        if (rsp_valid) begin
          check("rsp_pulse", 128'(prev_rv), 128'(0));
          if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp: got %0h expected none", act);
          end else begin
            check("rsp", 128'(act), 128'(exp_rsp.pop_front()));
          end
          last_rsp = act;
        end else begin
          check("rsp_hold", 128'(act), 128'(last_rsp));
        end
        prev_rv = rsp_valid;
      end
    end
  end

  task automatic send(input int op, input int sec);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end else begin
      model_cmd(op, sec);
      cmd_valid   = 1'b1;
      cmd_op      = 2'(op);
      cmd_section = 2'(sec);
      @(negedge clk);
      cmd_valid   = 1'b0;
      cmd_op      = 2'($urandom);
      cmd_section = 2'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_rsp.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_bus.size() != 0 || exp_rsp.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_bus.size() + exp_rsp.size());
      exp_bus.delete();
      exp_rsp.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {cmd_ready, rsp_valid, rsp_error, avm.avm_write, avm.avm_read,
                 avm.avm_address, avm.avm_writedata},
          {1'b1, 4'b0, 32'd0, 32'd0});
    check({name, "_rsp"}, {rsp_time, rsp_event}, 96'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // GO section 2, no stall: single write, cmd_ready back the cycle after
    wait_pct = 0;
    send(0, 2);
    #1;
    check("go_write", {avm.avm_write, avm.avm_address, avm.avm_writedata},
          {1'b1, BASE + 32'h24, 32'd0});
    @(negedge clk);
    #1;
    check("go_ready_back", {cmd_ready, avm.avm_write}, 2'b10);
    drain();

    // GLOBAL_RESET with three stalled cycles
    wr_hi_cycles = 0;
    stall_left = 3;
    send(2, 3);
    drain();
    check("greset_write_cycles", 128'(wr_hi_cycles), 128'(4));

    // READ section 1 with known words and one-cycle latency
    mem[4] = 32'h89AB_CDEF;
    mem[5] = 32'h0123_4567;
    mem[6] = 32'h0000_002A;
    max_lat = 1;
    send(3, 1);
    drain();
    check("read_s1", {rsp_time, rsp_event}, {64'h0123_4567_89AB_CDEF, 32'h0000_002A});

    // Random commands with random stalls and latencies
    wait_pct = 30;
    max_lat = 3;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) for (int j = 0; j < 16; j++) mem[j] = $urandom;
      send($urandom_range(0, 3), $urandom_range(0, NUM_SECTIONS - 1));
      drain();
    end

    // Reset while waiting for read data that never comes
    wait_pct = 0;
    mute = 1'b1;
    send(3, 2);
    repeat (2000) @(negedge clk);
    #1;
    check("stuck_busy", {cmd_ready, rsp_valid}, 2'b00);
    check("stuck_one_read", 128'(exp_bus.size()), 128'(2));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_bus.delete();
    exp_rsp.delete();
    @(negedge clk);
    pending = 1'b0;
    mute = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_pct = 30;
    send(3, 2);
    drain();
    check("read_after_reset", {rsp_time, rsp_event}, {mem[9], mem[8], mem[10]});

    check("final_queues", 128'(exp_bus.size() + exp_rsp.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/perf_counter_master.md
Name: perf_counter_master

Overview:
- Avalon-MM master that drives the 4-section performance-counter slave from hardware, so pipeline logic can time regions without the soft CPU.
- Accepts simple commands (GO, STOP, GLOBAL_RESET, READ) per section.
- Translates each command into the slave's write/read sequence.
- For READ, returns the 64-bit time count and 32-bit event count.
- Sits beside the CPU as a second master on the counter's control slave.

Parameters:
- ADDR_W, 32, width of avalon_address (byte address).
- BASE_ADDR, 32'h0000_0000, byte base address of the counter slave.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept command (high only in IDLE)
- cmd_op  in  2  0=GO, 1=STOP, 2=GLOBAL_RESET, 3=READ
- cmd_section  in  2  counter section 0..3
- rsp_valid  out  1  one-cycle pulse, READ result valid
- rsp_time  out  64  section time counter
- rsp_event  out  32  section event counter
- rsp_error  out  1  result aborted by timeout (optional feature only; tied 0 otherwise)
- avm_address  out  ADDR_W  byte address
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_writedata  out  32  write data
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data strobe

Behaviour:
- Interface: reset is reset_n, asynchronous, active-low; the clock is clk.
- Reset values:
  - All avm_* outputs 0.
  - cmd_ready 1.
  - rsp_valid 0; rsp_time 0; rsp_event 0; rsp_error 0.
  - FSM in IDLE.
- Word address mapping: word = section*4 + off; avm_address = BASE_ADDR + word*4.
  - GO: off=1.
  - STOP and GLOBAL_RESET: off=0, section forced to 0.
  - READ: off=0 (time lo), off=1 (time hi), off=2 (event).
- Write data: GO writes 0; STOP writes 0; GLOBAL_RESET writes 1 (bit0 set).
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- IDLE:
  - cmd_valid & cmd_ready captures op and section.
  - op 0..2 → WR; op 3 → RD_ISSUE with idx=0.
- WR:
  - avm_write=1 with address and data held stable until a cycle with avm_waitrequest=0.
  - Then → IDLE. cmd_ready reasserts the next cycle.
- RD_ISSUE:
  - avm_read=1 with address for idx, held until avm_waitrequest=0.
  - Then → RD_WAIT.
- RD_WAIT:
  - On avm_readdatavalid, store avm_readdata into slot idx.
  - If idx<2: idx++ → RD_ISSUE. Else → RESP.
  - readdatavalid arriving in the same cycle as the accepting cycle of the read (zero-latency fabric) is not expected. It is ignored, and the design must not hang; the verification engineer checks this with assertions.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_time={slot1,slot0}, rsp_event=slot2.
  - Then → IDLE. rsp_* data holds until the next READ completes.
- One outstanding transaction at most; reads are never pipelined.
- Torn read: hi and lo are read non-atomically. Consumers accept a torn value if lo wrapped between reads. This is documented, not corrected.
- readdatavalid outside RD_WAIT is ignored.
- cmd_valid while busy: not accepted (cmd_ready=0); the command must stay stable until accepted.
- reset_n asserted mid-transaction: immediate return to reset values. Any partial bus cycle is abandoned; the interconnect is reset on the same reset_n.

Optional Feature:
- Macro: PERF_COUNTER_MASTER_TIMEOUT_EN.
- With the macro:
  - A 16-bit watchdog counts cycles spent in WR, RD_ISSUE or RD_WAIT and clears on every state change.
  - At 16'hFFFF the FSM drops avm_read/avm_write and goes to RESP for READ (rsp_error=1, slots as captured so far), or to IDLE for writes.
  - rsp_error clears on the next accepted command.
- Without the macro: no watchdog; rsp_error is constant 0; the FSM may wait indefinitely.

Decomposition:
- Shared package perf_counter_pkg holds:
  - op encodings (OP_GO, OP_STOP, OP_GRESET, OP_READ);
  - word offsets (OFF_TIME_LO=0, OFF_TIME_HI=1, OFF_EVENT=2, OFF_STOP=0, OFF_GO=1);
  - SECTION_STRIDE=4; NUM_SECTIONS=4;
  - the FSM state enum.
- The slave is updated to use the same package constants.
- No sub-module: a single FSM plus a 3-slot capture register file.

Test Plan:
- GO section 2, waitrequest=0 → avm_write with address BASE+0x24, data 0, one cycle; cmd_ready back 1 the next cycle.
- GLOBAL_RESET with waitrequest held 3 cycles → address BASE+0x00, data 1 held stable 4 cycles, exactly one accepted write.
- READ section 1 against a slave model returning 0x89ABCDEF, 0x01234567, 0x0000002A with 1-cycle latency → reads at BASE+0x10, +0x14, +0x18; rsp_time=64'h01234567_89ABCDEF, rsp_event=0x2A, rsp_valid one cycle.
- Back-to-back GO s0 → READ s0 against the real counter slave after 100 idle cycles → rsp_event=1, rsp_time within the expected cycle window.
- reset_n pulsed during RD_WAIT → all outputs return to reset values; the next READ completes correctly.
- With PERF_COUNTER_MASTER_TIMEOUT_EN, readdatavalid never asserted → rsp_valid with rsp_error=1 after 65535 wait cycles; without the macro, still waiting after 70000 cycles.
